// File: rtl/branch_predictor_pkg.sv
// Shared predictor types: predMux select, 2-bit branch counter, BTB entry layout.
// Tags are held at the widest legal width (ENTRIES=2) and zero-extended for larger tables.
package branch_predictor_pkg;

   localparam int PC_W      = 32;
   localparam int TGT_W     = 30;
   localparam int TAG_MAX_W = 29;

   typedef enum logic {
      OPC = 1'b0,
      PPC = 1'b1
   } predMux;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } brCnt;

   typedef logic [TAG_MAX_W-1:0] tag_t;

   typedef struct packed {
      logic              valid;
      tag_t              tag;
      logic [TGT_W-1:0]  target;
      brCnt              cnt;
   } btb_entry_t;

   localparam btb_entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, target: '0, cnt: WNT};

   function automatic logic predicts_taken(input brCnt c);
      return (c == WT) || (c == ST);
   endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and branch-resolution signals between the pipeline (master) and predictor (slave).
// No handshake: lookup is combinational and every upd_en pulse is consumed in its cycle.
interface branch_predictor_if;
   import branch_predictor_pkg::*;

   logic [PC_W-1:0] fetch_pc;
   predMux          pred_sel;
   logic [PC_W-1:0] pred_target;
   logic            upd_en;
   logic [PC_W-1:0] upd_pc;
   logic [PC_W-1:0] upd_target;
   logic            upd_taken;
   logic            upd_pred;
   logic [31:0]     mispredict_cnt;

   modport master (
      output fetch_pc,
      output upd_en,
      output upd_pc,
      output upd_target,
      output upd_taken,
      output upd_pred,
      input  pred_sel,
      input  pred_target,
      input  mispredict_cnt
   );

   modport slave (
      input  fetch_pc,
      input  upd_en,
      input  upd_pc,
      input  upd_target,
      input  upd_taken,
      input  upd_pred,
      output pred_sel,
      output pred_target,
      output mispredict_cnt
   );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next state of a 2-bit saturating branch counter; purely combinational, zero latency.
// No backpressure: the result is valid whenever the inputs are.
module sat_counter2
   import branch_predictor_pkg::*;
(
   input  brCnt cnt_i,
   input  logic taken_i,
   output brCnt cnt_o
);

   always_comb begin
      cnt_o = cnt_i;
      case (cnt_i)
         SNT:     cnt_o = taken_i ? WNT : SNT;
         WNT:     cnt_o = taken_i ? WT  : SNT;
         WT:      cnt_o = taken_i ? ST  : WNT;
         ST:      cnt_o = taken_i ? ST  : WT;
         default: cnt_o = cnt_i;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup, training visible the cycle after the edge.
// No backpressure: one fetch lookup and at most one resolved-branch update accepted every cycle.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter  int ENTRIES = 16,
   localparam int IDX_W   = $clog2(ENTRIES),
   localparam int TAG_W   = 30 - IDX_W
)
(
   input  logic                clk_i,
   input  logic                rst_i,
   branch_predictor_if.slave   bp_if
);

   btb_entry_t          btb_q [ENTRIES];
   logic [31:0]         mispredict_cnt_q;
   logic [31:0]         mispredict_cnt_d;

   logic [IDX_W-1:0]    fetch_idx;
   logic [TAG_W-1:0]    fetch_tag_raw;
   tag_t                fetch_tag;
   btb_entry_t          fetch_entry;
   logic                fetch_hit;
   logic                fetch_ppc;

   logic [IDX_W-1:0]    upd_idx;
   logic [TAG_W-1:0]    upd_tag_raw;
   tag_t                upd_tag;
   btb_entry_t          upd_entry;
   btb_entry_t          upd_entry_d;
   logic                upd_hit;
   logic                upd_wr;
   brCnt                upd_cnt_next;

   // ---------------- lookup (reads pre-edge state, no bypass) ----------------
   assign fetch_idx     = bp_if.fetch_pc[IDX_W+1:2];
   assign fetch_tag_raw = bp_if.fetch_pc[31:IDX_W+2];
   assign fetch_tag     = tag_t'(fetch_tag_raw);
   assign fetch_entry   = btb_q[fetch_idx];
   assign fetch_hit     = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
   assign fetch_ppc     = fetch_hit && predicts_taken(fetch_entry.cnt);

   assign bp_if.pred_sel       = fetch_ppc ? PPC : OPC;
   assign bp_if.pred_target    = fetch_ppc ? {fetch_entry.target, 2'b00} : '0;
   assign bp_if.mispredict_cnt = mispredict_cnt_q;

   // ---------------- training ----------------
   assign upd_idx     = bp_if.upd_pc[IDX_W+1:2];
   assign upd_tag_raw = bp_if.upd_pc[31:IDX_W+2];
   assign upd_tag     = tag_t'(upd_tag_raw);
   assign upd_entry   = btb_q[upd_idx];
   assign upd_hit     = upd_entry.valid && (upd_entry.tag == upd_tag);

   sat_counter2 u_sat_counter2 (
      .cnt_i   (upd_entry.cnt),
      .taken_i (bp_if.upd_taken),
      .cnt_o   (upd_cnt_next)
   );

   always_comb begin
      upd_entry_d      = upd_entry;
      upd_wr           = 1'b0;
      mispredict_cnt_d = mispredict_cnt_q;
      if (bp_if.upd_en) begin
         if (upd_hit) begin
            upd_wr          = 1'b1;
            upd_entry_d.cnt = upd_cnt_next;
            if (bp_if.upd_taken) begin
               upd_entry_d.target = bp_if.upd_target[31:2];
            end
         end else if (bp_if.upd_taken) begin
            // Miss-taken allocates, evicting any aliasing branch at this index.
            upd_wr             = 1'b1;
            upd_entry_d.valid  = 1'b1;
            upd_entry_d.tag    = upd_tag;
            upd_entry_d.target = bp_if.upd_target[31:2];
            upd_entry_d.cnt    = WT;
         end
         if ((bp_if.upd_pred != bp_if.upd_taken) && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
            mispredict_cnt_d = mispredict_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb_q[i] <= ENTRY_RST;
         end
         mispredict_cnt_q <= '0;
      end else begin
         if (upd_wr) begin
            btb_q[upd_idx] <= upd_entry_d;
         end
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

endmodule
